// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath: per-instruction strobe sequencing
// with memory wait states, stall, JAL link write-back, illegal-command trap and retire pulse.
// Optional build macro MC_CTRL_OVF_TRAP_EN: arithmetic overflow on ADD/SUB/ADDI write-back traps.
//
// state  | meaning
// IF     | fetch, PC+4, waits MEM_WAIT cycles
// ID     | load A/B, precompute branch target
// EX_BR  | compare, conditional PC load
// EX_J   | jump (JAL also links PC into r31)
// EX_JR  | jump to register A
// EX_R   | register-register ALU op
// EX_I   | immediate ALU op / address calc
// MEM_LW | load read, waits MEM_WAIT cycles
// MEM_SW | store write, waits MEM_WAIT cycles
// WB_R   | write ALU result to rd
// WB_I   | write ALU result to rt
// WB_LW  | write MDR to rt
// TRAP   | halted, left only by reset
module multicycle_ctrl #(
  parameter int MEM_WAIT  = 0,
  parameter int CMD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 zero,
  input  logic                 ovf,
  input  logic [CMD_WIDTH-1:0] cmd,
  output logic [2:0]           aluOp,
  output logic [1:0]           pcSrc,
  output logic                 aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic                 memIn,
  output logic [1:0]           dst,
  output logic [1:0]           regIn,
  output logic                 pcWe,
  output logic                 irWe,
  output logic                 aWe,
  output logic                 bWe,
  output logic                 memWe,
  output logic                 regWe,
  output logic                 instrDone,
  output logic                 trap
);

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_BR, S_EX_J, S_EX_JR, S_EX_R, S_EX_I,
    S_MEM_LW, S_MEM_SW, S_WB_R, S_WB_I, S_WB_LW, S_TRAP
  } state_t;

  localparam logic [CMD_WIDTH-1:0] C_LW   = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] C_SW   = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] C_J    = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] C_JR   = CMD_WIDTH'(3);
  localparam logic [CMD_WIDTH-1:0] C_JAL  = CMD_WIDTH'(4);
  localparam logic [CMD_WIDTH-1:0] C_BEQ  = CMD_WIDTH'(5);
  localparam logic [CMD_WIDTH-1:0] C_BNE  = CMD_WIDTH'(6);
  localparam logic [CMD_WIDTH-1:0] C_XORI = CMD_WIDTH'(7);
  localparam logic [CMD_WIDTH-1:0] C_ADDI = CMD_WIDTH'(8);
  localparam logic [CMD_WIDTH-1:0] C_ADD  = CMD_WIDTH'(9);
  localparam logic [CMD_WIDTH-1:0] C_SUB  = CMD_WIDTH'(10);
  localparam logic [CMD_WIDTH-1:0] C_SLT  = CMD_WIDTH'(11);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] PC_ALU_RES = 2'd0;
  localparam logic [1:0] PC_ALU     = 2'd1;
  localparam logic [1:0] PC_J       = 2'd2;
  localparam logic [1:0] PC_A       = 2'd3;

  localparam logic [1:0] B_SXIS = 2'd0;
  localparam logic [1:0] B_SXI  = 2'd1;
  localparam logic [1:0] B_B    = 2'd2;
  localparam logic [1:0] B_FOUR = 2'd3;

  localparam logic [1:0] DST_RD = 2'd0;
  localparam logic [1:0] DST_RT = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] RIN_MDR = 2'd0;
  localparam logic [1:0] RIN_ALU = 2'd1;
  localparam logic [1:0] RIN_PC  = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t               state_q, state_d, nxt;
  logic [3:0]           wait_q, wait_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic                 trap_q, trap_d;
  logic                 en, mem_rdy, ovf_fault;

  assign en      = !reset && !stall;
  assign mem_rdy = (wait_q == 4'd0);
  assign trap    = trap_q;

`ifdef MC_CTRL_OVF_TRAP_EN
  assign ovf_fault = ovf && (((state_q == S_WB_R) && ((cmd_q == C_ADD) || (cmd_q == C_SUB))) ||
                             ((state_q == S_WB_I) && (cmd_q == C_ADDI)));
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
  assign ovf_fault  = 1'b0;
`endif

  always_comb begin
    nxt       = state_q;
    aluOp     = ALU_ADD;
    pcSrc     = PC_ALU_RES;
    aluSrcA   = 1'b0;
    aluSrcB   = B_SXIS;
    memIn     = 1'b0;
    dst       = DST_RD;
    regIn     = RIN_MDR;
    pcWe      = 1'b0;
    irWe      = 1'b0;
    aWe       = 1'b0;
    bWe       = 1'b0;
    memWe     = 1'b0;
    regWe     = 1'b0;
    case (state_q)
      S_IF: begin
        aluSrcB = B_FOUR;
        pcSrc   = PC_ALU;
        if (mem_rdy) begin
          irWe = en;
          pcWe = en;
          nxt  = S_ID;
        end
      end
      S_ID: begin
        aWe = en;
        bWe = en;
        case (cmd)
          C_BEQ, C_BNE:                 nxt = S_EX_BR;
          C_J, C_JAL:                   nxt = S_EX_J;
          C_JR:                         nxt = S_EX_JR;
          C_ADD, C_SUB, C_SLT:          nxt = S_EX_R;
          C_XORI, C_ADDI, C_LW, C_SW:   nxt = S_EX_I;
          default:                      nxt = S_TRAP;
        endcase
      end
      S_EX_BR: begin
        aluSrcA = 1'b1;
        aluSrcB = B_B;
        aluOp   = ALU_SUB;
        pcWe    = en && ((cmd_q == C_BEQ) ? zero : !zero);
        nxt     = S_IF;
      end
      S_EX_J: begin
        pcSrc = PC_J;
        pcWe  = en;
        if (cmd_q == C_JAL) begin
          regWe = en;
          dst   = DST_RA;
          regIn = RIN_PC;
        end
        nxt = S_IF;
      end
      S_EX_JR: begin
        pcSrc = PC_A;
        pcWe  = en;
        nxt   = S_IF;
      end
      S_EX_R: begin
        aluSrcA = 1'b1;
        aluSrcB = B_B;
        aluOp   = (cmd_q == C_SUB) ? ALU_SUB : (cmd_q == C_SLT) ? ALU_SLT : ALU_ADD;
        nxt     = S_WB_R;
      end
      S_EX_I: begin
        aluSrcA = 1'b1;
        aluSrcB = B_SXI;
        aluOp   = (cmd_q == C_XORI) ? ALU_XOR : ALU_ADD;
        nxt     = (cmd_q == C_LW) ? S_MEM_LW : (cmd_q == C_SW) ? S_MEM_SW : S_WB_I;
      end
      S_MEM_LW: begin
        memIn = 1'b1;
        if (mem_rdy) nxt = S_WB_LW;
      end
      S_MEM_SW: begin
        memIn = 1'b1;
        if (mem_rdy) begin
          memWe = en;
          nxt   = S_IF;
        end
      end
      S_WB_R, S_WB_I: begin
        dst   = (state_q == S_WB_R) ? DST_RD : DST_RT;
        regIn = RIN_ALU;
        regWe = en && !ovf_fault;
        nxt   = ovf_fault ? S_TRAP : S_IF;
      end
      S_WB_LW: begin
        dst   = DST_RT;
        regIn = RIN_MDR;
        regWe = en;
        nxt   = S_IF;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_IF;
    endcase

    state_d   = stall ? state_q : nxt;
    // Retire marks the transition into IF, not the wait cycles spent inside it.
    instrDone = en && (state_q != S_IF) && (nxt == S_IF);

    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = WAIT_INIT;
    else if (!stall && !mem_rdy &&
             ((state_q == S_IF) || (state_q == S_MEM_LW) || (state_q == S_MEM_SW)))
      wait_d = wait_q - 4'd1;

    cmd_d  = (state_q == S_ID) ? cmd : cmd_q;
    trap_d = trap_q || (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      wait_q  <= WAIT_INIT;
      cmd_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cmd_q   <= cmd_d;
      trap_q  <= trap_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: three instances (MEM_WAIT 0/1/2), driver pushes
// hand-written per-cycle output vectors, monitor pops and compares the selected instance.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       memIn;
    logic [1:0] dst;
    logic [1:0] regIn;
    logic       pcWe, irWe, aWe, bWe, memWe, regWe, instrDone, trap;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       zero = 1'b0;
  logic       ovf = 1'b0;
  logic [3:0] cmd = 4'd0;
  int         sel = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  outs_t      outs [3];
  outs_t      exp_q [$];
  string      nm_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [2:0] aluOp;
    logic [1:0] pcSrc, aluSrcB, dst, regIn;
    logic       aluSrcA, memIn, pcWe, irWe, aWe, bWe, memWe, regWe, instrDone, trap;
    multicycle_ctrl #(.MEM_WAIT(g), .CMD_WIDTH(4)) u_dut (
      .clk(clk), .reset(reset), .stall(stall), .zero(zero), .ovf(ovf), .cmd(cmd),
      .aluOp(aluOp), .pcSrc(pcSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .memIn(memIn),
      .dst(dst), .regIn(regIn), .pcWe(pcWe), .irWe(irWe), .aWe(aWe), .bWe(bWe),
      .memWe(memWe), .regWe(regWe), .instrDone(instrDone), .trap(trap)
    );
    assign outs[g] = {aluOp, pcSrc, aluSrcA, aluSrcB, memIn, dst, regIn,
                      pcWe, irWe, aWe, bWe, memWe, regWe, instrDone, trap};
  end

  // en = {pcWe, irWe, aWe, bWe, memWe, regWe, instrDone, trap}
  function automatic outs_t mk(input int alu, input int pcs, input int sa, input int sb,
                               input int mi, input int ds, input int ri, input logic [7:0] en);
    outs_t v;
    v.aluOp   = 3'(alu);
    v.pcSrc   = 2'(pcs);
    v.aluSrcA = 1'(sa);
    v.aluSrcB = 2'(sb);
    v.memIn   = 1'(mi);
    v.dst     = 2'(ds);
    v.regIn   = 2'(ri);
    {v.pcWe, v.irWe, v.aWe, v.bWe, v.memWe, v.regWe, v.instrDone, v.trap} = en;
    return v;
  endfunction

  outs_t IF_WAIT, IF_GO, ID_V, EXR_ADD, EXR_SUB, EXR_SLT, WBR, EXI_ADD, EXI_XOR, WBI;
  outs_t EXBR_T, EXBR_N, EXJ, EXJAL, EXJR, MEM_W, MEMSW_GO, WBLW, TRAPV, WBR_OVF;

  task automatic cyc(input outs_t e, input string nm, input logic [3:0] c,
                     input logic z = 1'b0, input logic o = 1'b0,
                     input logic s = 1'b0, input logic r = 1'b0);
    @(posedge clk);
    #1;
    cmd   = c;
    zero  = z;
    ovf   = o;
    stall = s;
    reset = r;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // One unchecked reset cycle, then a checked one (state already IF, enables forced low).
  task automatic rst(input int w);
    @(posedge clk);
    #1;
    sel   = w;
    reset = 1'b1;
    stall = 1'b0;
    cyc(IF_WAIT, "reset_state", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outs_t e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      a  = outs[sel];
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s (W=%0d t=%0t): got %h expected %h", nm, sel, $time, a, e);
      end
    end
  end

  initial begin
    IF_WAIT  = mk(0, 1, 0, 3, 0, 0, 0, 8'b0000_0000);
    IF_GO    = mk(0, 1, 0, 3, 0, 0, 0, 8'b1100_0000);
    ID_V     = mk(0, 0, 0, 0, 0, 0, 0, 8'b0011_0000);
    EXR_ADD  = mk(0, 0, 1, 2, 0, 0, 0, 8'b0000_0000);
    EXR_SUB  = mk(1, 0, 1, 2, 0, 0, 0, 8'b0000_0000);
    EXR_SLT  = mk(3, 0, 1, 2, 0, 0, 0, 8'b0000_0000);
    WBR      = mk(0, 0, 0, 0, 0, 0, 1, 8'b0000_0110);
    WBR_OVF  = mk(0, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
    EXI_ADD  = mk(0, 0, 1, 1, 0, 0, 0, 8'b0000_0000);
    EXI_XOR  = mk(2, 0, 1, 1, 0, 0, 0, 8'b0000_0000);
    WBI      = mk(0, 0, 0, 0, 0, 1, 1, 8'b0000_0110);
    EXBR_T   = mk(1, 0, 1, 2, 0, 0, 0, 8'b1000_0010);
    EXBR_N   = mk(1, 0, 1, 2, 0, 0, 0, 8'b0000_0010);
    EXJ      = mk(0, 2, 0, 0, 0, 0, 0, 8'b1000_0010);
    EXJAL    = mk(0, 2, 0, 0, 0, 2, 2, 8'b1000_0110);
    EXJR     = mk(0, 3, 0, 0, 0, 0, 0, 8'b1000_0010);
    MEM_W    = mk(0, 0, 0, 0, 1, 0, 0, 8'b0000_0000);
    MEMSW_GO = mk(0, 0, 0, 0, 1, 0, 0, 8'b0000_1010);
    WBLW     = mk(0, 0, 0, 0, 0, 1, 0, 8'b0000_0110);
    TRAPV    = mk(0, 0, 0, 0, 0, 0, 0, 8'b0000_0001);

    // ---------------- MEM_WAIT = 0 ----------------
    rst(0);
    cyc(IF_GO, "add_if", 4'd9); cyc(ID_V, "add_id", 4'd9);
    cyc(EXR_ADD, "add_ex", 4'd9); cyc(WBR, "add_wb", 4'd9);
    cyc(IF_GO, "xori_if", 4'd7); cyc(ID_V, "xori_id", 4'd7);
    cyc(EXI_XOR, "xori_ex", 4'd7); cyc(WBI, "xori_wb", 4'd7);
    cyc(IF_GO, "beq_if", 4'd5, 1'b1); cyc(ID_V, "beq_id", 4'd5, 1'b1);
    cyc(EXBR_T, "beq_taken", 4'd5, 1'b1);
    cyc(IF_GO, "bne_if", 4'd6, 1'b1); cyc(ID_V, "bne_id", 4'd6, 1'b1);
    cyc(EXBR_N, "bne_not_taken", 4'd6, 1'b1);
    cyc(IF_GO, "bne2_if", 4'd6); cyc(ID_V, "bne2_id", 4'd6);
    cyc(EXBR_T, "bne_taken", 4'd6, 1'b0, 1'b1);
    cyc(IF_GO, "jal_if", 4'd4); cyc(ID_V, "jal_id", 4'd4); cyc(EXJAL, "jal_ex", 4'd4);
    cyc(IF_GO, "j_if", 4'd2); cyc(ID_V, "j_id", 4'd2); cyc(EXJ, "j_ex", 4'd2);
    cyc(IF_GO, "jr_if", 4'd3); cyc(ID_V, "jr_id", 4'd3); cyc(EXJR, "jr_ex", 4'd3);
    cyc(IF_GO, "slt_if", 4'd11); cyc(ID_V, "slt_id", 4'd11);
    cyc(EXR_SLT, "slt_ex_cmd_ignored", 4'd9); cyc(WBR, "slt_wb", 4'd9);
    cyc(IF_GO, "stall_id_if", 4'd9);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 8'b0), "id_stalled", 4'd9, 1'b0, 1'b0, 1'b1);
    cyc(ID_V, "id_released", 4'd9); cyc(EXR_ADD, "stall_add_ex", 4'd9);
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 8'b0), "wb_stalled", 4'd9, 1'b0, 1'b0, 1'b1);
    cyc(WBR, "wb_released", 4'd9);
    cyc(IF_GO, "sub_if", 4'd10); cyc(ID_V, "sub_id", 4'd10);
    cyc(EXR_SUB, "sub_ex", 4'd10, 1'b0, 1'b1);
`ifdef MC_CTRL_OVF_TRAP_EN
    cyc(WBR_OVF, "sub_ovf_wb", 4'd10, 1'b0, 1'b1);
    cyc(TRAPV, "ovf_trap", 4'd9); cyc(TRAPV, "ovf_trap_hold", 4'd9);
    rst(0);
`else
    cyc(WBR, "sub_ovf_ignored", 4'd10, 1'b0, 1'b1);
`endif
    cyc(IF_GO, "ill_if", 4'd13); cyc(ID_V, "ill_id", 4'd13);
    cyc(TRAPV, "trap_enter", 4'd13); cyc(TRAPV, "trap_hold_add", 4'd9);
    cyc(TRAPV, "trap_hold_j", 4'd2, 1'b1, 1'b1);
    rst(0);
    cyc(IF_GO, "post_trap_if", 4'd2); cyc(ID_V, "post_trap_id", 4'd2); cyc(EXJ, "post_trap_j", 4'd2);

    // ---------------- MEM_WAIT = 2 ----------------
    rst(2);
    cyc(IF_WAIT, "lw_if1", 4'd0); cyc(IF_WAIT, "lw_if2", 4'd0); cyc(IF_GO, "lw_if3", 4'd0);
    cyc(ID_V, "lw_id", 4'd0); cyc(EXI_ADD, "lw_ex", 4'd0);
    cyc(MEM_W, "lw_mem1", 4'd0); cyc(MEM_W, "lw_mem2", 4'd0); cyc(MEM_W, "lw_mem3", 4'd0);
    cyc(WBLW, "lw_wb", 4'd0);
    cyc(IF_WAIT, "j_if1", 4'd2); cyc(IF_WAIT, "j_if2", 4'd2); cyc(IF_GO, "j_if3", 4'd2);
    cyc(ID_V, "j_id_w2", 4'd2); cyc(EXJ, "j_ex_w2", 4'd2);
    cyc(IF_WAIT, "addi_if1", 4'd8);
    cyc(IF_WAIT, "addi_if_stall", 4'd8, 1'b0, 1'b0, 1'b1);
    cyc(IF_WAIT, "addi_if2", 4'd8); cyc(IF_GO, "addi_if3", 4'd8);
    cyc(ID_V, "addi_id", 4'd8); cyc(EXI_ADD, "addi_ex", 4'd8); cyc(WBI, "addi_wb", 4'd8);

    // ---------------- MEM_WAIT = 1 ----------------
    rst(1);
    cyc(IF_WAIT, "sw_if1", 4'd1); cyc(IF_GO, "sw_if2", 4'd1);
    cyc(ID_V, "sw_id", 4'd1); cyc(EXI_ADD, "sw_ex", 4'd1);
    cyc(MEM_W, "sw_mem1", 4'd1);
    for (int i = 0; i < 3; i++) cyc(MEM_W, "sw_mem_stalled", 4'd1, 1'b0, 1'b0, 1'b1);
    cyc(MEMSW_GO, "sw_mem_write", 4'd1);
    cyc(IF_WAIT, "rst_addi_if1", 4'd8); cyc(IF_GO, "rst_addi_if2", 4'd8);
    cyc(ID_V, "rst_addi_id", 4'd8);
    cyc(EXI_ADD, "ex_i_under_reset", 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(IF_WAIT, "after_reset_if1", 4'd8); cyc(IF_GO, "after_reset_if2", 4'd8);
    cyc(ID_V, "addi2_id", 4'd8); cyc(EXI_ADD, "addi2_ex", 4'd8); cyc(WBI, "addi2_wb", 4'd8);

    @(negedge clk);
    @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised control FSM for the multicycle MIPS core; next generation of the current `fsm` controller. Sits beside the datapath, decodes the 4-bit command from the instruction decoder, and sequences PC, IR, A/B, register-file and memory strobes per instruction. Adds over the current controller:
- synchronous reset;
- configurable memory wait states;
- a pipeline-style stall input;
- jump-and-link write-back of the PC;
- an illegal-command trap;
- an instruction-retire pulse.

## Interface
Parameters:
- `MEM_WAIT`, 0: extra wait cycles inserted in every memory-access state (IF, MEM_LW, MEM_SW); legal range 0..15.
- `CMD_WIDTH`, 4: width of `cmd`. Codes: LW=0, SW=1, J=2, JR=3, JAL=4, BEQ=5, BNE=6, XORI=7, ADDI=8, ADD=9, SUB=10, SLT=11. All other codes are illegal.

Ports (clock and reset first):
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: freeze request.
- `zero` input 1: ALU zero flag.
- `ovf` input 1: ALU overflow flag.
- `cmd` input CMD_WIDTH: decoded command; valid from the ID cycle onward.
- `aluOp` output 3: ADD=0, SUB=1, XOR=2, SLT=3.
- `pcSrc` output 2: ALU_RES=0, ALU=1, J=2, A=3.
- `aluSrcA` output 1: PC=0, A=1.
- `aluSrcB` output 2: SXIS=0, SXI=1, B=2, FOUR=3.
- `memIn` output 1: PC=0, ALU_RES=1.
- `dst` output 2: RD=0, RT=1, RA=2 (reg 31).
- `regIn` output 2: MDR=0, ALU_RES=1, PC=2.
- `pcWe`, `irWe`, `aWe`, `bWe`, `memWe`, `regWe` output 1 each: write enables.
- `instrDone` output 1: retire pulse.
- `trap` output 1: illegal-command / fault flag, sticky until reset.

## Operation
Outputs are Moore-decoded from the state register, except the gated enables and the branch `pcWe`. Mux selects not listed for a state are 0. Write enables not listed for a state are 0.

State register, all enables, wait counter:
- Reset: state=IF, wait counter=MEM_WAIT, `trap`=0. While `reset` is high, every write enable and `instrDone` are forced to 0.
- Wait counter: loaded with MEM_WAIT on entry to IF, MEM_LW and MEM_SW; decrements each unstalled cycle. Memory states exit, and assert their enables, only in the cycle where the counter is 0.

States and per-state behaviour:
- IF: memIn=PC, aluSrcA=PC, aluSrcB=FOUR, aluOp=ADD, pcSrc=ALU. irWe and pcWe are asserted on the final wait cycle only. Then -> ID.
- ID: aWe=bWe=1; aluSrcA=PC, aluSrcB=SXIS, aluOp=ADD (branch target precomputed into the ALU result register). Dispatch on `cmd`:
  - BEQ/BNE -> EX_BR
  - J/JAL -> EX_J
  - JR -> EX_JR
  - ADD/SUB/SLT -> EX_R
  - XORI/ADDI/LW/SW -> EX_I
  - illegal -> TRAP
- EX_BR: aluSrcA=A, aluSrcB=B, aluOp=SUB, pcSrc=ALU_RES. pcWe=zero (BEQ) or !zero (BNE). -> IF.
- EX_J: pcSrc=J, pcWe=1. For JAL only, additionally regWe=1, dst=RA, regIn=PC (the already-incremented PC is written). -> IF.
- EX_JR: pcSrc=A, pcWe=1. -> IF.
- EX_R: aluSrcA=A, aluSrcB=B, aluOp=ADD/SUB/SLT per cmd. -> WB_R.
- EX_I: aluSrcA=A, aluSrcB=SXI; aluOp=XOR for XORI, otherwise ADD. Next state:
  - XORI/ADDI -> WB_I
  - LW -> MEM_LW
  - SW -> MEM_SW
- MEM_LW: memIn=ALU_RES. -> WB_LW.
- MEM_SW: memIn=ALU_RES, memWe=1. -> IF.
- WB_R: regWe=1, dst=RD, regIn=ALU_RES. -> IF.
- WB_I: regWe=1, dst=RT, regIn=ALU_RES. -> IF.
- WB_LW: regWe=1, dst=RT, regIn=MDR. -> IF.
- TRAP: all enables 0, `trap`=1. Left only by reset.

Retire:
- `instrDone` is 1 in any unstalled cycle whose next state is IF.

## Timing
- Cycles per instruction: J, JAL, JR, BEQ, BNE = 3+W; ADD, SUB, SLT, XORI, ADDI = 4+W; SW = 4+2W; LW = 5+2W (W=MEM_WAIT).
- `stall`=1 holds the state and the wait counter. It forces all write enables and `instrDone` to 0; mux selects keep their state-decoded values. Stall takes effect in the same cycle it is asserted; release resumes with no lost or repeated strobe.
- `reset` has priority over `stall`. Reset mid-instruction abandons it: the next cycle is IF with no enable pulse during the reset cycle.
- `cmd` is sampled only in ID; changes in other states are ignored.
- `ovf` is ignored unless MC_CTRL_OVF_TRAP_EN is defined. Branch decisions never use `ovf`.

## Configuration
- `MC_CTRL_OVF_TRAP_EN` defined: in WB_R (ADD, SUB) and WB_I (ADDI), `ovf`=1 suppresses regWe, sets `trap`, and the next state is TRAP; `instrDone` stays 0. SLT and XORI are unaffected.
- Undefined: overflow is ignored and write-back always occurs.

## Test plan
- Reset, MEM_WAIT=0, cmd=ADD: strobes are IF{irWe,pcWe}, ID{aWe,bWe}, EX_R{aluOp=ADD}, WB_R{regWe, dst=RD}; `instrDone` is high in the WB_R cycle; total 4 cycles.
- MEM_WAIT=2, cmd=LW: irWe only in IF cycle 3; MEM_LW lasts 3 cycles; regWe with regIn=MDR, dst=RT; total 9 cycles.
- BEQ with zero=1, then BNE with zero=1: pcWe=1, pcSrc=ALU_RES in the first EX_BR; pcWe=0 in the second; each takes 3 cycles.
- JAL: EX_J asserts pcWe (pcSrc=J) and regWe (dst=RA, regIn=PC) in the same cycle.
- `stall` held 3 cycles during MEM_SW (MEM_WAIT=1): memWe stays low during the stall and pulses exactly once afterward; `reset` asserted mid-EX_I returns to IF with no regWe.
- cmd=13 -> TRAP, `trap`=1, all enables 0 until reset. With MC_CTRL_OVF_TRAP_EN, ADD with ovf=1 -> no regWe, `trap`=1.
